// File: rtl/bsg_manycore_perf_counter_responder.sv
// bsg_manycore_perf_counter_responder
//
// Synthesizable per-tile performance counter block that sits on the manycore
// remote load/store network as a responder. It keeps one saturating counter
// per event strobe plus a free-running cycle counter. Remote loads and stores
// read and write these counters. Every accepted request gets exactly one
// return packet, which is either load data or a store acknowledgement.
//
// Register map (word addresses):
//   0 .. num_events_p-1 : event counter k
//   num_events_p        : cycle counter
//   num_events_p+1      : control (bit0 enable r/w, bit1 clear, write-only)
//   anything else       : out of range (load returns 0, store dropped, err_o set)
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-low reset
//   freeze_i                 tile freeze, inhibits counting; falling edge clears
//   event_i                  per-cycle event strobes, one per counter
//   req_*                    incoming request (valid/ready handshake)
//   resp_*                   outgoing response (valid/ready handshake)
//   err_o                    sticky out-of-range access flag

module bsg_manycore_perf_counter_responder #(
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 16,
    parameter int x_cord_width_p  = 2,
    parameter int y_cord_width_p  = 3,
    parameter int load_id_width_p = 11,
    parameter int num_events_p    = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       freeze_i,
    input  logic [num_events_p-1:0]    event_i,

    input  logic                       req_v_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [addr_width_p-1:0]    req_addr_i,
    input  logic [data_width_p-1:0]    req_data_i,
    input  logic [x_cord_width_p-1:0]  req_src_x_i,
    input  logic [y_cord_width_p-1:0]  req_src_y_i,
    input  logic [load_id_width_p-1:0] req_load_id_i,

    output logic                       resp_v_o,
    input  logic                       resp_ready_i,
    output logic                       resp_is_store_o,
    output logic [data_width_p-1:0]    resp_data_o,
    output logic [load_id_width_p-1:0] resp_load_id_o,
    output logic [x_cord_width_p-1:0]  resp_dst_x_o,
    output logic [y_cord_width_p-1:0]  resp_dst_y_o,
    output logic                       err_o
);

    localparam logic [addr_width_p-1:0] ctrl_addr_lp = addr_width_p'(num_events_p + 1);

    typedef enum logic {IDLE, RESP} state_e;

    state_e state_r, state_n;

    // Index num_events_p is the cycle counter.
    logic [data_width_p-1:0] counters_r [num_events_p+1];
    logic                    enable_r;
    logic                    freeze_r;
    logic                    err_r;

    logic                    is_store_r;
    logic [data_width_p-1:0] data_r;
    logic [load_id_width_p-1:0] load_id_r;
    logic [x_cord_width_p-1:0]  dst_x_r;
    logic [y_cord_width_p-1:0]  dst_y_r;

    logic                    handshake;
    logic                    wr;
    logic                    ctrl_wr;
    logic                    in_range;
    logic                    unfreeze;
    logic                    clear_all;
    logic                    count_en;
    logic [num_events_p:0]   inc_sources;
    logic [data_width_p-1:0] read_data;

    assign req_ready_o = (state_r == IDLE);
    assign resp_v_o    = (state_r == RESP);

    assign handshake   = req_v_i & req_ready_o;
    assign wr          = handshake & req_we_i;
    assign in_range    = (req_addr_i <= ctrl_addr_lp);
    assign ctrl_wr     = wr & (req_addr_i == ctrl_addr_lp);
    assign unfreeze    = freeze_r & ~freeze_i;
    // An explicit clear and the unfreeze edge both beat stores and increments.
    assign clear_all   = unfreeze | (ctrl_wr & req_data_i[1]);
    assign count_en    = enable_r & ~freeze_i;
    // The cycle counter counts on every enabled cycle.
    assign inc_sources = {1'b1, event_i};

    // Load data comes from the counters before this cycle's update.
    // The clear bit is write-only and always reads back as 0.
    always_comb begin
        read_data = '0;
        for (int i = 0; i <= num_events_p; i++) begin
            if (req_addr_i == addr_width_p'(i)) begin
                read_data = counters_r[i];
            end
        end
        if (req_addr_i == ctrl_addr_lp) begin
            read_data = {{(data_width_p-1){1'b0}}, enable_r};
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (req_v_i)      state_n = RESP;
            RESP:    if (resp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i <= num_events_p; i++) begin
                counters_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= num_events_p; i++) begin
                if (clear_all) begin
                    counters_r[i] <= '0;
                end else if (wr && (req_addr_i == addr_width_p'(i))) begin
                    counters_r[i] <= req_data_i;
                end else if (count_en && inc_sources[i] && !(&counters_r[i])) begin
                    counters_r[i] <= counters_r[i] + data_width_p'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            enable_r <= 1'b1;
            freeze_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            freeze_r <= freeze_i;
            if (ctrl_wr) begin
                enable_r <= req_data_i[0];
            end
            if (handshake && !in_range) begin
                err_r <= 1'b1;
            end
        end
    end

    // The response fields are captured at acceptance and then held. The data
    // therefore stays stable while the counters keep running.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            is_store_r <= 1'b0;
            data_r     <= '0;
            load_id_r  <= '0;
            dst_x_r    <= '0;
            dst_y_r    <= '0;
        end else if (handshake) begin
            is_store_r <= req_we_i;
            data_r     <= req_we_i ? '0 : read_data;
            load_id_r  <= req_load_id_i;
            dst_x_r    <= req_src_x_i;
            dst_y_r    <= req_src_y_i;
        end
    end

    assign resp_is_store_o = is_store_r;
    assign resp_data_o     = data_r;
    assign resp_load_id_o  = load_id_r;
    assign resp_dst_x_o    = dst_x_r;
    assign resp_dst_y_o    = dst_y_r;
    assign err_o           = err_r;

endmodule

// File: tb/tb_bsg_manycore_perf_counter_responder.sv
// Testbench for bsg_manycore_perf_counter_responder: directed scenarios
// followed by a randomized phase. Every cycle is checked against a
// behavioural model of the register map.

module tb_bsg_manycore_perf_counter_responder;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        freeze_i;
    logic [N-1:0] event_i;
    logic        req_v_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [15:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [1:0]  req_src_x_i;
    logic [2:0]  req_src_y_i;
    logic [10:0] req_load_id_i;
    logic        resp_v_o;
    logic        resp_ready_i;
    logic        resp_is_store_o;
    logic [31:0] resp_data_o;
    logic [10:0] resp_load_id_o;
    logic [1:0]  resp_dst_x_o;
    logic [2:0]  resp_dst_y_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_cnt [N+1];
    logic        m_en, m_frz, m_err, m_busy, m_is_store;
    logic [31:0] m_data;
    logic [10:0] m_id;
    logic [1:0]  m_x;
    logic [2:0]  m_y;

    always #5 clk = ~clk;

    bsg_manycore_perf_counter_responder dut (
        .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i), .event_i(event_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i),
        .req_load_id_i(req_load_id_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
        .resp_is_store_o(resp_is_store_o), .resp_data_o(resp_data_o),
        .resp_load_id_o(resp_load_id_o), .resp_dst_x_o(resp_dst_x_o),
        .resp_dst_y_o(resp_dst_y_o), .err_o(err_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= N; k++) m_cnt[k] = '0;
        m_en = 1'b1; m_frz = 1'b0; m_err = 1'b0; m_busy = 1'b0;
        m_is_store = 1'b0; m_data = '0; m_id = '0; m_x = '0; m_y = '0;
    endtask

    // One clock edge's worth of behaviour, computed from the current inputs.
    task automatic model_step();
        int          a;
        logic        accept;
        logic        clr;
        a      = int'(req_addr_i);
        accept = !m_busy && req_v_i;
        if (m_busy && resp_ready_i) m_busy = 1'b0;
        if (accept) begin
            m_is_store = req_we_i;
            if (req_we_i)        m_data = 32'd0;
            else if (a <= N)     m_data = m_cnt[a];
            else if (a == N + 1) m_data = {31'd0, m_en};
            else                 m_data = 32'd0;
            m_id = req_load_id_i; m_x = req_src_x_i; m_y = req_src_y_i;
            if (a > N + 1) m_err = 1'b1;
            m_busy = 1'b1;
        end
        clr = (m_frz && !freeze_i) || (accept && req_we_i && a == N + 1 && req_data_i[1]);
        for (int k = 0; k <= N; k++) begin
            if (clr) m_cnt[k] = 32'd0;
            else if (accept && req_we_i && a == k) m_cnt[k] = req_data_i;
            else if (m_en && !freeze_i && (k == N || event_i[k]) && m_cnt[k] != 32'hFFFF_FFFF)
                m_cnt[k] = m_cnt[k] + 32'd1;
        end
        if (accept && req_we_i && a == N + 1) m_en = req_data_i[0];
        m_frz = freeze_i;
    endtask

    task automatic checkAll();
        checkOutput("req_ready", 32'(req_ready_o), 32'(!m_busy));
        checkOutput("resp_v", 32'(resp_v_o), 32'(m_busy));
        checkOutput("err", 32'(err_o), 32'(m_err));
        if (m_busy) begin
            checkOutput("resp_is_store", 32'(resp_is_store_o), 32'(m_is_store));
            checkOutput("resp_data", resp_data_o, m_data);
            checkOutput("resp_load_id", 32'(resp_load_id_o), 32'(m_id));
            checkOutput("resp_x", 32'(resp_dst_x_o), 32'(m_x));
            checkOutput("resp_y", 32'(resp_dst_y_o), 32'(m_y));
        end
    endtask

    // Advance one clock with the current inputs, then compare against the model.
    task automatic applyStimulus();
        model_step();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    // Issue one request. On return the response is presented and has not yet
    // been consumed.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] data);
        req_v_i       = 1'b1;
        req_we_i      = we;
        req_addr_i    = addr;
        req_data_i    = data;
        req_load_id_i = 11'($urandom);
        req_src_x_i   = 2'($urandom);
        req_src_y_i   = 3'($urandom);
        applyStimulus();
        req_v_i = 1'b0;
        checkOutput("latency_resp_v", 32'(resp_v_o), 32'd1);
        checkOutput("echo_id", 32'(resp_load_id_o), 32'(req_load_id_i));
    endtask

    task automatic consume();
        resp_ready_i = 1'b1;
        applyStimulus();
    endtask

    initial begin
        logic [31:0] held;
        reset_i = 1'b0; freeze_i = 1'b0; event_i = '0; req_v_i = 1'b0; req_we_i = 1'b0;
        req_addr_i = '0; req_data_i = '0; req_src_x_i = '0; req_src_y_i = '0;
        req_load_id_i = '0; resp_ready_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst_resp_v", 32'(resp_v_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_resp_data", resp_data_o, 32'd0);
        checkOutput("rst_resp_id", 32'(resp_load_id_o), 32'd0);
        reset_i = 1'b1;

        // Ten cycles of event 0, then read counter 0.
        event_i = 8'h01;
        repeat (10) applyStimulus();
        event_i = '0;
        do_req(1'b0, 16'd0, 32'd0);
        checkOutput("tp1_data", resp_data_o, 32'd10);
        checkOutput("tp1_is_store", 32'(resp_is_store_o), 32'd0);
        consume();

        // Saturation.
        do_req(1'b1, 16'd3, 32'hFFFF_FFFE);
        consume();
        event_i = 8'h08;
        repeat (5) applyStimulus();
        event_i = '0;
        do_req(1'b0, 16'd3, 32'd0);
        checkOutput("tp2_saturate", resp_data_o, 32'hFFFF_FFFF);
        consume();

        // A store beats an increment in the same cycle.
        event_i = 8'h08;
        do_req(1'b1, 16'd3, 32'h1234_5678);
        event_i = '0;
        checkOutput("tp3_ack_store", 32'(resp_is_store_o), 32'd1);
        checkOutput("tp3_ack_data", resp_data_o, 32'd0);
        consume();
        do_req(1'b0, 16'd3, 32'd0);
        checkOutput("tp3_value", resp_data_o, 32'h1234_5678);
        consume();

        // Freeze with all events high, then unfreeze.
        freeze_i = 1'b1; event_i = 8'hFF;
        repeat (20) applyStimulus();
        freeze_i = 1'b0; event_i = '0;
        applyStimulus();
        do_req(1'b0, 16'd8, 32'd0);
        checkOutput("tp4_cycle_zero", resp_data_o, 32'd0);
        consume();
        do_req(1'b0, 16'd8, 32'd0);
        checkOutput("tp4_cycle_inc", resp_data_o, 32'd2);
        consume();
        do_req(1'b0, 16'd3, 32'd0);
        checkOutput("tp4_cnt3_zero", resp_data_o, 32'd0);
        consume();

        // Out-of-range accesses.
        do_req(1'b0, 16'd100, 32'd0);
        checkOutput("tp5_oor_load", resp_data_o, 32'd0);
        checkOutput("tp5_err", 32'(err_o), 32'd1);
        consume();
        do_req(1'b1, 16'd12, 32'hDEAD_BEEF);
        checkOutput("tp5_oor_ack", 32'(resp_is_store_o), 32'd1);
        consume();
        do_req(1'b0, 16'd0, 32'd0);
        checkOutput("tp5_cnt0_unchanged", resp_data_o, 32'd0);
        checkOutput("tp5_err_sticky", 32'(err_o), 32'd1);
        consume();

        // Stalled response, then asynchronous reset while it is pending.
        event_i = 8'h01;
        resp_ready_i = 1'b0;
        do_req(1'b0, 16'd8, 32'd0);
        held = m_data;
        req_v_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus();
            checkOutput("tp6_stall_ready", 32'(req_ready_o), 32'd0);
            checkOutput("tp6_stall_data", resp_data_o, held);
        end
        #3;
        reset_i = 1'b0;
        #1;
        checkOutput("tp6_rst_resp_v", 32'(resp_v_o), 32'd0);
        checkOutput("tp6_rst_ready", 32'(req_ready_o), 32'd1);
        checkOutput("tp6_rst_err", 32'(err_o), 32'd0);
        model_reset();
        req_v_i = 1'b0; event_i = '0; resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        do_req(1'b0, 16'd0, 32'd0);
        checkOutput("tp6_cnt0_cleared", resp_data_o, 32'd0);
        consume();
        do_req(1'b0, 16'd9, 32'd0);
        checkOutput("tp6_enable_reset", resp_data_o, 32'd1);
        consume();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) freeze_i = ~freeze_i;
            event_i       = 8'($urandom);
            req_v_i       = 1'($urandom);
            req_we_i      = ($urandom_range(0, 2) == 0);
            req_addr_i    = 16'($urandom_range(0, 11));
            req_load_id_i = 11'($urandom);
            req_src_x_i   = 2'($urandom);
            req_src_y_i   = 3'($urandom);
            if (req_addr_i == 16'd9)
                req_data_i = {30'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
            else
                req_data_i = $urandom;
            resp_ready_i  = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
